mem_port_arbiter: RTL and testbench

Shares one single-ported instruction/data memory between the pipeline's IF-stage fetch requester and its MEM-stage load/store requester. Grants one transaction at a time and holds registered request attributes stable until the memory acknowledges. Returns the result to the owning requester with a one-cycle ready pulse. Requesters stall on their own req-without-ready; a branch/jump redirect can kill an outstanding fetch.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data requesters; one transaction in flight.
// Optional ARB_STARVE_GUARD_EN: after MAX_DATA_GRANTS data grants with fetch waiting, fetch wins once.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_GRANTS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_kill,
  output logic                o_if_ready,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [DATA_W/8-1:0] i_d_be,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  output logic                o_d_ready,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_ack_i;
  logic                w_ack_d;
  logic                w_fetch_ok;
  logic                w_fetch_first;
  logic                w_fetch_dead;
  logic                r_kill;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_ready;
  logic                r_d_ready;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  assign w_fetch_ok   = i_if_req && !i_if_kill;
  // A kill raised in the ack cycle itself must also suppress delivery.
  assign w_fetch_dead = r_kill || i_if_kill;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_DATA_GRANTS + 1);
  logic [CNT_W-1:0] r_dgrants;

  assign w_fetch_first = (r_dgrants >= CNT_W'(MAX_DATA_GRANTS));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dgrants <= '0;
    end else if (w_grant_i) begin
      r_dgrants <= '0;
    end else if (w_grant_d && w_fetch_ok) begin
      r_dgrants <= r_dgrants + 1'b1;
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    w_ack_i     = 1'b0;
    w_ack_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_d_req && !(w_fetch_first && w_fetch_ok)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_BUSY_D;
        end else if (w_fetch_ok) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I: begin
        if (i_mem_ack) begin
          w_ack_i     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY_D: begin
        if (i_mem_ack) begin
          w_ack_d     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_kill      <= 1'b0;
    end else begin
      r_if_ready <= w_ack_i && !w_fetch_dead;
      r_d_ready  <= w_ack_d;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= i_d_we;
        r_mem_be    <= i_d_be;
        r_mem_addr  <= i_d_addr;
        r_mem_wdata <= i_d_wdata;
      end else if (w_grant_i) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_be   <= '1;
        r_mem_addr <= i_if_addr;
      end else if (w_ack_i || w_ack_d) begin
        r_mem_req <= 1'b0;
      end
      if (w_ack_i && !w_fetch_dead) begin
        r_if_rdata <= i_mem_rdata;
      end
      if (w_ack_d && !r_mem_we) begin
        r_d_rdata <= i_mem_rdata;
      end
      if (w_ack_i) begin
        r_kill <= 1'b0;
      end else if (r_state == S_BUSY_I && i_if_kill) begin
        r_kill <= 1'b1;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_ready  = r_if_ready;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_ready   = r_d_ready;
  assign o_d_rdata   = r_d_rdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXG = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_req = 1'b0, if_kill = 1'b0;
  logic [AW-1:0]   if_addr = '0;
  logic            d_req = 1'b0, d_we = 1'b0;
  logic [DW/8-1:0] d_be = '0;
  logic [AW-1:0]   d_addr = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic            resp_ack = 1'b0, poke_ack = 1'b0;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata = '0;
  logic            if_ready, d_ready, mem_req, mem_we, busy;
  logic [DW-1:0]   if_rdata, d_rdata, mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;

  assign mem_ack = resp_ack | poke_ack;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_GRANTS(MAXG)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_ready(if_ready), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ready(d_ready), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h10:  rdata_for = 32'h13;
      32'h30:  rdata_for = 32'h1234;
      default: rdata_for = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory responder: acks each request after mem_wait extra cycles.
  int mem_wait = 0;
  int rcnt = 0;
  bit racked = 1'b0;
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (!rst || !mem_req) begin
      racked = 1'b0;
      rcnt   = 0;
    end else if (!racked) begin
      if (rcnt >= mem_wait) begin
        resp_ack  = 1'b1;
        mem_rdata = rdata_for(mem_addr);
        racked    = 1'b1;
      end else begin
        rcnt++;
      end
    end
  end

  // Records which requester owns each new memory request (fetch uses 0x400 in the fairness test).
  byte gseq[$];
  bit  rec_on = 1'b0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (rec_on && mem_req && !prev_req) gseq.push_back((mem_addr == 32'h400) ? "I" : "D");
    prev_req = mem_req;
  end

  // Transaction model: owner 0=none, 1=fetch, 2=data; starve counts data wins over a waiting fetch.
  int            m_owner = 0;
  int            starve = 0;
  bit            fetch_dead = 1'b0;
  logic          e_req = 1'b0, e_we = 1'b0, e_if_ready = 1'b0, e_d_ready = 1'b0;
  logic [3:0]    e_be = '0;
  logic [31:0]   e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; starve = 0; fetch_dead = 1'b0;
      e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
      e_if_ready = 1'b0; e_d_ready = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      e_if_ready = 1'b0;
      e_d_ready  = 1'b0;
      if (m_owner == 0) begin
        bit wants_fetch;
        bit fetch_turn;
        wants_fetch = if_req && !if_kill;
        fetch_turn  = GUARD && (starve >= MAXG) && wants_fetch;
        if (d_req && !fetch_turn) begin
          m_owner = 2; e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
          if (GUARD && wants_fetch) starve++;
        end else if (wants_fetch) begin
          m_owner = 1; e_we = 1'b0; e_be = 4'hF; e_addr = if_addr;
          starve = 0; fetch_dead = 1'b0;
        end
      end else begin
        if (m_owner == 1 && if_kill) fetch_dead = 1'b1;
        if (mem_ack) begin
          if (m_owner == 1 && !fetch_dead) begin
            e_if_ready = 1'b1; e_if_rdata = mem_rdata;
          end
          if (m_owner == 2) begin
            e_d_ready = 1'b1;
            if (!e_we) e_d_rdata = mem_rdata;
          end
          m_owner = 0;
        end
      end
    end
    e_req = (m_owner != 0);
  end

  always @(negedge clk) begin
    chk("mdl_mem_req", mem_req, e_req);
    chk("mdl_busy", busy, e_req);
    chk("mdl_mem_we", mem_we, e_we);
    chk("mdl_mem_be", mem_be, e_be);
    chk("mdl_mem_addr", mem_addr, e_addr);
    chk("mdl_mem_wdata", mem_wdata, e_wdata);
    chk("mdl_if_ready", if_ready, e_if_ready);
    chk("mdl_d_ready", d_ready, e_d_ready);
    chk("mdl_if_rdata", if_rdata, e_if_rdata);
    chk("mdl_d_rdata", d_rdata, e_d_rdata);
  end

  task automatic wait_ready(input bit fetch, input string nm);
    int n;
    n = 0;
    while (!(fetch ? if_ready : d_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (n < 100), 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (n < 100), 1'b1);
  endtask

  initial begin
    string exp_seq;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Fetch only, zero-wait memory.
    if_req = 1'b1; if_addr = 32'h10; mem_wait = 0;
    @(negedge clk);
    chk("f_mem_req_c1", mem_req, 1'b1);
    chk("f_mem_addr_c1", mem_addr, 32'h10);
    chk("f_mem_be_c1", mem_be, 4'hF);
    @(negedge clk);
    chk("f_if_ready_c2", if_ready, 1'b1);
    chk("f_if_rdata_c2", if_rdata, 32'h13);
    if_req = 1'b0;
    @(negedge clk);
    chk("f_if_ready_c3", if_ready, 1'b0);

    // Stray ack while idle must be ignored.
    poke_ack = 1'b1;
    @(negedge clk);
    poke_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_if_ready", if_ready, 1'b0);
    chk("idle_ack_d_ready", d_ready, 1'b0);

    // Simultaneous requests: data first.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    chk("both_first_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("both_d_ready", d_ready, 1'b1);
    chk("both_d_rdata", d_rdata, 32'h5A5A_0100);
    d_req = 1'b0;
    @(negedge clk);
    chk("both_second_req", mem_req, 1'b1);
    chk("both_second_addr", mem_addr, 32'h20);
    @(negedge clk);
    chk("both_if_ready", if_ready, 1'b1);
    chk("both_if_rdata", if_rdata, 32'h5A5A_0020);
    if_req = 1'b0;
    @(negedge clk);

    // Store with three wait cycles.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; mem_wait = 3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("st_mem_req", mem_req, 1'b1);
      chk("st_mem_we", mem_we, 1'b1);
      chk("st_mem_be", mem_be, 4'b0011);
      chk("st_mem_addr", mem_addr, 32'h40);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk("st_d_ready", d_ready, 1'b1);
    chk("st_d_rdata_held", d_rdata, 32'h5A5A_0100);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    // Kill an outstanding fetch.
    if_req = 1'b1; if_addr = 32'h30; mem_wait = 2;
    @(negedge clk);
    chk("kill_mem_addr", mem_addr, 32'h30);
    if_kill = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_kill = 1'b0;
    @(negedge clk);
    chk("kill_busy_c3", busy, 1'b1);
    @(negedge clk);
    chk("kill_no_ready", if_ready, 1'b0);
    chk("kill_busy_done", busy, 1'b0);
    chk("kill_rdata_held", if_rdata, 32'h5A5A_0020);
    // Kill in IDLE blocks the grant for that cycle only.
    if_req = 1'b1; if_addr = 32'h80; if_kill = 1'b1; mem_wait = 0;
    @(negedge clk);
    chk("kill_idle_blocks", busy, 1'b0);
    if_kill = 1'b0;
    wait_ready(1'b1, "refetch_timeout");
    chk("refetch_rdata", if_rdata, 32'h5A5A_0080);
    if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset during a data transaction.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_wait = 1000;
    @(negedge clk);
    chk("rstmid_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_mem_req", mem_req, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    mem_wait = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_regrant_req", mem_req, 1'b1);
    chk("rstmid_regrant_addr", mem_addr, 32'h200);
    wait_ready(1'b0, "rstmid_timeout");
    chk("rstmid_d_rdata", d_rdata, 32'h5A5A_0200);
    d_req = 1'b0;
    @(negedge clk);

    // Both requesters held high: fairness pattern.
    gseq.delete();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h400;
    rec_on = 1'b1;
    repeat (40) @(negedge clk);
    rec_on = 1'b0;
    d_req = 1'b0; if_req = 1'b0;
    wait_idle("fair_drain");
    repeat (2) @(negedge clk);
    exp_seq = GUARD ? "DDDDIDDDDI" : "DDDDDDDDDD";
    chk("fair_count", (gseq.size() >= 10), 1'b1);
    for (int i = 0; i < 10 && i < gseq.size(); i++) begin
      chk("fair_grant", {24'h0, gseq[i]}, {24'h0, exp_seq[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
